// File: rtl/snes_joypad_ctrl.sv
// snes_joypad_ctrl: schedules periodic reads of the SNES shift engine. It waits
// for the completion handshake with a timeout, then debounces the 12 buttons and
// tracks whether a controller is present. The result is presented as the
// Gameboy P1/FF00 nibble, and a joypad interrupt pulse marks new presses.
// Optional feature: define SNES_TURBO_EN to let X/Y act as auto-fire A/B.
module snes_joypad_ctrl #(
    parameter int POLL_DIV     = 66667,
    parameter int DEBOUNCE_CNT = 2,
    parameter int TIMEOUT      = 1024
`ifdef SNES_TURBO_EN
    ,
    parameter int TURBO_POLLS  = 4
`endif
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic        poll_start,
    input  logic        poll_done,
    input  logic [15:0] poll_data,
    input  logic [1:0]  p1_sel,
    output logic [3:0]  p1_out,
    output logic [11:0] buttons_db,
    output logic        joy_irq,
    output logic        ctrl_present,
    output logic        err_timeout
);

    localparam int DIV_W = $clog2(POLL_DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    // Each nibble, from LSB to MSB, holds the SNES bit index for one Gameboy
    // input, in the order A, B, Select, Start, Right, Up, Left, Down.
    localparam logic [31:0] GB_MAP = {4'd5, 4'd6, 4'd4, 4'd7, 4'd3, 4'd2, 4'd0, 4'd8};

    typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg;
    logic               poll_tick;
    logic [TO_W-1:0]    tcnt_reg;
    logic               tcnt_expired;
    logic [15:0]        data_reg;
    logic [11:0]        cand_reg, cand_next;
    logic [2:0]         count_reg, count_next;
    logic [11:0]        buttons_db_reg, buttons_db_next;
    logic [11:0]        sample;
    logic               present;
    logic               ctrl_present_reg, err_timeout_reg, joy_irq_reg;
    logic [7:0]         gb_cur, gb_next;
    logic [3:0]         dir, btn;

    assign poll_tick    = (div_reg == DIV_W'(POLL_DIV - 1));
    assign tcnt_expired = (tcnt_reg == TO_W'(TIMEOUT - 1));

    assign buttons_db   = buttons_db_reg;
    assign ctrl_present = ctrl_present_reg;
    assign err_timeout  = err_timeout_reg;
    assign joy_irq      = joy_irq_reg;

    // Free-running poll divider; it never stops, so the poll period stays fixed.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)         div_reg <= '0;
        else if (poll_tick) div_reg <= '0;
        else                div_reg <= div_reg + DIV_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic. A tick outside IDLE is skipped, and poll_done beats expiry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (poll_tick) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (poll_done)         state_next = UPDATE;
                else if (tcnt_expired) state_next = IDLE;
            end
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: the read request is high only during START.
    always_comb begin
        poll_start = (state_reg == START);
    end

    // Timeout counter. It is cleared in START, so WAIT lasts at most TIMEOUT cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                  tcnt_reg <= '0;
        else if (state_reg == START) tcnt_reg <= '0;
        else if (state_reg == WAIT)  tcnt_reg <= tcnt_reg + TO_W'(1);
    end

    // Sample conditioning and debounce candidate tracking for the captured word.
    always_comb begin
        present    = (data_reg[15:12] == 4'hF);
        sample     = present ? ~data_reg[11:0] : 12'h000;
        cand_next  = cand_reg;
        count_next = count_reg;
        if (sample == cand_reg) begin
            if (count_reg < 3'(DEBOUNCE_CNT)) count_next = count_reg + 3'd1;
        end else begin
            cand_next  = sample;
            count_next = 3'd1;
        end
        buttons_db_next = (count_next >= 3'(DEBOUNCE_CNT)) ? cand_next : buttons_db_reg;
    end

`ifdef SNES_TURBO_EN
    localparam int TP_W = (TURBO_POLLS > 1) ? $clog2(TURBO_POLLS) : 1;
    logic [TP_W-1:0] tp_cnt_reg;
    logic            turbo_phase_reg, turbo_phase_upd, tp_wrap;

    assign tp_wrap         = (tp_cnt_reg == TP_W'(TURBO_POLLS - 1));
    assign turbo_phase_upd = tp_wrap ? ~turbo_phase_reg : turbo_phase_reg;

    // Turbo phase flips once every TURBO_POLLS completed polls.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tp_cnt_reg      <= '0;
            turbo_phase_reg <= 1'b0;
        end else if (state_reg == UPDATE) begin
            tp_cnt_reg      <= tp_wrap ? '0 : tp_cnt_reg + TP_W'(1);
            turbo_phase_reg <= turbo_phase_upd;
        end
    end
`endif

    // Map the current and post-update button sets onto the 8 Gameboy inputs.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_map
            localparam int SRC = int'(GB_MAP[gi*4 +: 4]);
`ifdef SNES_TURBO_EN
            if (gi == 0) begin : g_turbo_a
                assign gb_cur[gi]  = buttons_db_reg[SRC]  | (buttons_db_reg[9]  & turbo_phase_reg);
                assign gb_next[gi] = buttons_db_next[SRC] | (buttons_db_next[9] & turbo_phase_upd);
            end else if (gi == 1) begin : g_turbo_b
                assign gb_cur[gi]  = buttons_db_reg[SRC]  | (buttons_db_reg[1]  & turbo_phase_reg);
                assign gb_next[gi] = buttons_db_next[SRC] | (buttons_db_next[1] & turbo_phase_upd);
            end else begin : g_plain
                assign gb_cur[gi]  = buttons_db_reg[SRC];
                assign gb_next[gi] = buttons_db_next[SRC];
            end
`else
            assign gb_cur[gi]  = buttons_db_reg[SRC];
            assign gb_next[gi] = buttons_db_next[SRC];
`endif
        end
    endgenerate

    // Capture, debounce state, presence, sticky timeout and the interrupt pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_reg         <= 16'h0000;
            cand_reg         <= 12'h000;
            count_reg        <= 3'd0;
            buttons_db_reg   <= 12'h000;
            ctrl_present_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
            joy_irq_reg      <= 1'b0;
        end else begin
            joy_irq_reg <= 1'b0;
            if (state_reg == WAIT && poll_done)
                data_reg <= poll_data;
            if (state_reg == WAIT && !poll_done && tcnt_expired)
                err_timeout_reg <= 1'b1;
            if (state_reg == UPDATE) begin
                cand_reg         <= cand_next;
                count_reg        <= count_next;
                buttons_db_reg   <= buttons_db_next;
                ctrl_present_reg <= present;
                err_timeout_reg  <= 1'b0;
                joy_irq_reg      <= |(gb_next & ~gb_cur);
            end
        end
    end

    // Gameboy P1 nibble: active-low lines, gated by the active-low selects.
    always_comb begin
        dir    = ~{gb_cur[7], gb_cur[5], gb_cur[6], gb_cur[4]};
        btn    = ~gb_cur[3:0];
        p1_out = (p1_sel[0] ? 4'hF : dir) & (p1_sel[1] ? 4'hF : btn);
    end

endmodule

// File: tb/tb_snes_joypad_ctrl.sv
// tb_snes_joypad_ctrl: directed polls with a scoreboard. The stimulus pushes
// the expected settled result of each poll. The monitor pops and compares that
// entry when the DUT issues the next poll_start.
module tb_snes_joypad_ctrl;

    localparam int POLL_DIV = 16;
    localparam int DB_CNT   = 2;
    localparam int TMO      = 8;

    logic        clock;
    logic        rst_n;
    logic        poll_start;
    logic        poll_done;
    logic [15:0] poll_data;
    logic [1:0]  p1_sel;
    logic [3:0]  p1_out;
    logic [11:0] buttons_db;
    logic        joy_irq;
    logic        ctrl_present;
    logic        err_timeout;

    snes_joypad_ctrl #(
        .POLL_DIV     (POLL_DIV),
        .DEBOUNCE_CNT (DB_CNT),
        .TIMEOUT      (TMO)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .poll_start   (poll_start),
        .poll_done    (poll_done),
        .poll_data    (poll_data),
        .p1_sel       (p1_sel),
        .p1_out       (p1_out),
        .buttons_db   (buttons_db),
        .joy_irq      (joy_irq),
        .ctrl_present (ctrl_present),
        .err_timeout  (err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] db;
        logic        pres;
        logic        err;
        logic [3:0]  p1;
        int          irq_at;    // cycle after poll_start where joy_irq is high, 0 = none
        int          err_rise;  // cycle after poll_start where err_timeout rises, 0 = none
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // ---------------- monitor ----------------
    int   gap = 0;
    bit   have_prev = 1'b0;
    int   irq_cnt = 0;
    int   irq_pos = 0;
    int   err_pos = 0;
    logic err_prev = 1'b0;
    int   poll_idx = 0;

    always @(negedge clock) begin
        exp_t e;
        if (!rst_n) begin
            gap       = 0;
            have_prev = 1'b1;
            irq_cnt   = 0;
            irq_pos   = 0;
            err_pos   = 0;
            err_prev  = 1'b0;
        end else begin
            gap++;
            if (poll_start) begin
                if (have_prev) chk("poll_period", gap, POLL_DIV);
                have_prev = 1'b1;
                if (sb.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] poll %0d: db=%03h pres=%0b err=%0b p1=%h irq=%0d@%0d err_rise=%0d",
                             poll_idx, buttons_db, ctrl_present, err_timeout, p1_out,
                             irq_cnt, irq_pos, err_pos);
                    chk("buttons_db", buttons_db, e.db);
                    chk("ctrl_present", ctrl_present, e.pres);
                    chk("err_timeout", err_timeout, e.err);
                    chk("p1_out", p1_out, e.p1);
                    chk("irq_count", irq_cnt, (e.irq_at != 0) ? 1 : 0);
                    if (e.irq_at != 0) chk("irq_cycle", irq_pos, e.irq_at);
                    chk("err_rise_cycle", err_pos, e.err_rise);
                end
                poll_idx++;
                gap      = 0;
                irq_cnt  = 0;
                irq_pos  = 0;
                err_pos  = 0;
                err_prev = err_timeout;
            end else begin
                if (joy_irq) begin
                    irq_cnt++;
                    if (irq_pos == 0) irq_pos = gap;
                end
                if (err_timeout && !err_prev) err_pos = gap;
                err_prev = err_timeout;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_start();
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!poll_start && t < 3 * POLL_DIV);
        if (!poll_start) begin
            chk("poll_start_seen", 0, 1);
            summary();
        end
    endtask

    // delay: WAIT cycle (1..TMO) in which poll_done is driven; 0 = no response.
    task automatic do_poll(input logic [15:0] data, input int delay, input logic [1:0] sel,
                           input logic [11:0] e_db, input logic e_pres, input logic e_err,
                           input logic [3:0] e_p1, input int e_irq_at, input int e_err_rise);
        exp_t e;
        wait_start();
        e.db = e_db; e.pres = e_pres; e.err = e_err; e.p1 = e_p1;
        e.irq_at = e_irq_at; e.err_rise = e_err_rise;
        sb.push_back(e);
        @(negedge clock);
        p1_sel = sel;
        if (delay > 0) begin
            repeat (delay - 1) @(negedge clock);
            poll_done = 1'b1;
            poll_data = data;
            @(negedge clock);
            poll_done = 1'b0;
        end
    endtask

    initial begin
        exp_t r;
        rst_n     = 1'b0;
        poll_done = 1'b0;
        poll_data = 16'hFFFF;
        p1_sel    = 2'b11;
        r.db = 12'h000; r.pres = 1'b0; r.err = 1'b0; r.p1 = 4'hF; r.irq_at = 0; r.err_rise = 0;
        sb.push_back(r);
        repeat (3) @(negedge clock);
        #1 rst_n = 1'b1;

        // alternating B / released: never stable for two polls
        do_poll(16'hFFFE, 1, 2'b01, 12'h000, 1, 0, 4'hF,    0, 0);
        do_poll(16'hFFFF, 1, 2'b01, 12'h000, 1, 0, 4'hF,    0, 0);
        do_poll(16'hFFFE, 1, 2'b01, 12'h000, 1, 0, 4'hF,    0, 0);
        do_poll(16'hFFFF, 1, 2'b01, 12'h000, 1, 0, 4'hF,    0, 0);
        // B held for two polls
        do_poll(16'hFFFE, 1, 2'b01, 12'h000, 1, 0, 4'hF,    0, 0);
        do_poll(16'hFFFE, 1, 2'b01, 12'h001, 1, 0, 4'b1101, 3, 0);
        // no response: timeout, then a response in the expiry cycle clears it
        do_poll(16'hFFFE, 0, 2'b01, 12'h001, 1, 1, 4'b1101, 0, 9);
        do_poll(16'hFFFE, 8, 2'b01, 12'h001, 1, 0, 4'b1101, 0, 0);
        // X added: debounced, but no GB effect and no interrupt
        do_poll(16'hFDFE, 1, 2'b01, 12'h001, 1, 0, 4'b1101, 0, 0);
        do_poll(16'hFDFE, 1, 2'b01, 12'h201, 1, 0, 4'b1101, 0, 0);
        // L+R+B: L/R never interrupt
        do_poll(16'hF3FE, 1, 2'b01, 12'h201, 1, 0, 4'b1101, 0, 0);
        do_poll(16'hF3FE, 1, 2'b01, 12'hC01, 1, 0, 4'b1101, 0, 0);
        // controller absent: presence drops, buttons decay
        do_poll(16'h0000, 1, 2'b11, 12'hC01, 0, 0, 4'hF,    0, 0);
        do_poll(16'h0000, 1, 2'b10, 12'h000, 0, 0, 4'hF,    0, 0);
        // Up+Start, both selects low; second response arrives late
        do_poll(16'hFFE7, 1, 2'b00, 12'h000, 1, 0, 4'hF,    0, 0);
        do_poll(16'hFFE7, 8, 2'b00, 12'h018, 1, 0, 4'b0011, 10, 0);
        // A+Right on the direction select
        do_poll(16'hFE7F, 1, 2'b10, 12'h018, 1, 0, 4'b1011, 0, 0);
        do_poll(16'hFE7F, 1, 2'b10, 12'h180, 1, 0, 4'b1110, 3, 0);
        // Down+Left+Select
        do_poll(16'hFF9B, 1, 2'b01, 12'h180, 1, 0, 4'b1110, 0, 0);
        do_poll(16'hFF9B, 1, 2'b00, 12'h064, 1, 0, 4'b0001, 3, 0);
        do_poll(16'hFFE7, 1, 2'b00, 12'h064, 1, 0, 4'b0001, 0, 0);
        do_poll(16'hFFE7, 1, 2'b00, 12'h018, 1, 0, 4'b0011, 3, 0);

        // reset in the middle of a poll, then stray poll_done pulses in IDLE
        wait_start();
        @(negedge clock);
        @(negedge clock);
        rst_n  = 1'b0;
        p1_sel = 2'b11;
        sb.push_back(r);
        repeat (3) @(negedge clock);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clock);
        poll_data = 16'hFFFE;
        poll_done = 1'b1;
        @(negedge clock);
        poll_done = 1'b0;
        @(negedge clock);
        poll_done = 1'b1;
        @(negedge clock);
        poll_done = 1'b0;
        do_poll(16'hFFFF, 1, 2'b11, 12'h000, 1, 0, 4'hF, 0, 0);

        wait_start();
        @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        summary();
    end

    initial begin
        #200000;
        chk("global_time_limit", 0, 1);
        summary();
    end

endmodule

// File: doc/snes_joypad_ctrl.md
Name: snes_joypad_ctrl

Overview:
- Poll scheduler and input conditioner for the SNES controller shift engine.
- Periodically triggers a controller read and waits for the completion handshake (with timeout), then debounces the 12 button bits and detects controller presence.
- Presents the result as the Gameboy P1/FF00 joypad nibble and raises a joypad interrupt pulse on new presses.
- Sits between the SNES shift engine and the Gameboy core's I/O register block.

Parameters:
- POLL_DIV, 66667: clock cycles between poll starts (60 Hz at 4 MHz).
- DEBOUNCE_CNT, 2: consecutive identical polls required before buttons_db updates (1 to 7).
- TIMEOUT, 1024: cycles to wait for poll_done after poll_start.
- TURBO_POLLS, 4: polls per turbo phase toggle (used only with SNES_TURBO_EN).

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- poll_start  out  1  one-cycle pulse requesting a shift-engine read
- poll_done  in  1  one-cycle pulse; poll_data valid in the same cycle
- poll_data  in  16  raw shifted word; bit 0 = B ... bit 11 = R, bits 15:12 ID; 0 = pressed
- p1_sel  in  2  Gameboy select lines, active-low; [0] = P14 directions, [1] = P15 buttons
- p1_out  out  4  Gameboy P13..P10, active-low
- buttons_db  out  12  debounced buttons, 1 = pressed
- joy_irq  out  1  one-cycle joypad interrupt pulse
- ctrl_present  out  1  controller detected on last completed poll
- err_timeout  out  1  sticky: last poll timed out

Behaviour:
- Reset (async assert, sync deassert use):
  - state IDLE; divider, timeout counter, debounce count and candidate all 0.
  - poll_start = 0, buttons_db = 0, joy_irq = 0, ctrl_present = 0, err_timeout = 0.
  - p1_out = 4'hF.
  - Reset mid-poll abandons the poll; a later stray poll_done is ignored (state is IDLE).
- FSM:
  - IDLE: divider counts 0..POLL_DIV-1. At POLL_DIV-1, divider wraps to 0 and state goes to START.
  - START: poll_start = 1 for exactly this cycle; timeout counter cleared; go to WAIT.
  - WAIT:
    - poll_done = 1: capture poll_data, go to UPDATE.
    - Timeout counter reaches TIMEOUT-1 without poll_done: set err_timeout, go to IDLE; no button change.
    - poll_done and expiry in the same cycle: poll_done wins.
  - UPDATE: one cycle; apply debounce and interrupt logic; clear err_timeout; go to IDLE.
- poll_done in IDLE, START or UPDATE is ignored.
- The divider keeps running in every state, so the poll period stays exactly POLL_DIV cycles. A poll tick that occurs while not in IDLE is skipped.
- Presence: present = (poll_data[15:12] == 4'hF). ctrl_present updates in UPDATE. When absent, the sample is forced to 12'h000 (all released).
- Sample: s = ~poll_data[11:0] (active-high pressed), or 0 if absent.
- Debounce:
  - If s == candidate: count increments, saturating at DEBOUNCE_CNT. Otherwise candidate = s and count = 1.
  - When count (after update) >= DEBOUNCE_CNT, buttons_db = candidate.
  - Latency to buttons_db: DEBOUNCE_CNT polls plus 1 cycle after the final poll_done.
- joy_irq: pulses the cycle after UPDATE if (new_db & ~old_db) is nonzero on any of the 8 GB-mapped bits [8,0,2,3,7,4,6,5]. L and R never interrupt; X and Y only with turbo enabled.
- p1_out (combinational from buttons_db and p1_sel):
  - dir = ~{Down, Up, Left, Right}
  - btn = ~{Start, Select, B, A}
  - p1_out = (p1_sel[0] ? 4'hF : dir) & (p1_sel[1] ? 4'hF : btn)
  - Both selects low gives the AND of both nibbles; neither low gives 4'hF.

Optional Feature:
- Macro: SNES_TURBO_EN.
- Defined:
  - turbo_phase register (reset 0) toggles every TURBO_POLLS completed polls.
  - GB A = A | (X & turbo_phase); GB B = B | (Y & turbo_phase). These feed both p1_out and the joy_irq bit set.
- Undefined: X and Y have no effect on p1_out or joy_irq; no turbo logic is present.

Test Plan:
- Reset with POLL_DIV=16: poll_start pulses at cycles 16, 32, 48 after rst_n rises, each exactly 1 cycle wide; p1_out = 4'hF.
- DEBOUNCE_CNT=2, poll_data = 16'hFFFE (B pressed) on two consecutive polls → buttons_db = 12'h001 one cycle after the second poll_done; joy_irq pulses once; with p1_sel = 2'b01, p1_out = 4'b1101.
- poll_data alternating 16'hFFFE / 16'hFFFF each poll → buttons_db stays 0 and joy_irq never fires.
- No poll_done after poll_start with TIMEOUT=8 → err_timeout = 1 eight cycles after poll_start; the next good poll clears it.
- poll_data = 16'h0000 → ctrl_present = 0 and buttons_db decays to 0 after DEBOUNCE_CNT polls; Up+Start pressed with p1_sel = 2'b00 → p1_out = 4'b0111 & 4'b1011 = 4'b0011.
- SNES_TURBO_EN defined, X held, TURBO_POLLS=1: the GB A bit in p1_out (p1_sel = 2'b01) toggles every poll, and joy_irq pulses on each released→pressed phase.
